// File: rtl/conv_aip_pkg.sv
// Shared AIP target codes, sequencer state encodings and the job-length clamp.
package conv_aip_pkg;
  localparam logic [4:0] CFG_MEMIN0_PTR  = 5'h00;
  localparam logic [4:0] CFG_MEMIN0      = 5'h01;
  localparam logic [4:0] CFG_MEMOUT0_PTR = 5'h02;
  localparam logic [4:0] CFG_MEMOUT0     = 5'h03;
  localparam logic [4:0] CFG_CONFREG_PTR = 5'h04;
  localparam logic [4:0] CFG_CONFREG     = 5'h05;
  localparam logic [4:0] CFG_STATUS      = 5'h1E;

  localparam logic [31:0] INT_CLR_DONE = 32'h1;

  localparam logic [3:0] ST_IDLE     = 4'd0,  ST_PTR_IN   = 4'd1,  ST_WR_IN   = 4'd2,
                         ST_WR_CONF  = 4'd3,  ST_START    = 4'd4,  ST_WAIT_INT = 4'd5,
                         ST_CLR_INT  = 4'd6,  ST_PTR_OUT  = 4'd7,  ST_RD_ISSUE = 4'd8,
                         ST_RD_WAIT  = 4'd9,  ST_RD_HOLD  = 4'd10, ST_FIN      = 4'd11;

  function automatic logic [6:0] clamp_len(input logic [6:0] len, input logic [6:0] max_len);
    if (len == 7'd0) return 7'd1;
    if (len > max_len) return max_len;
    return len;
  endfunction
endpackage

// File: rtl/conv_aip_rd_port.sv
// Read-return path: READ_LAT-deep strobe delay line, then a single result register
// exposed with valid/ready; out_data holds until the consumer takes it.
module conv_aip_rd_port #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_issue,
  input  logic [15:0] rd_data,
  input  logic        out_ready,
  output logic        cap,
  output logic        out_valid,
  output logic [15:0] out_data
);
  logic [READ_LAT-1:0] pipe_q, pipe_d;
  logic                vld_q, vld_d;
  logic [15:0]         dat_q, dat_d;

  // Oldest stage marks the cycle in which the AIP read data is valid.
  assign cap       = pipe_q[READ_LAT-1];
  assign out_valid = vld_q;
  assign out_data  = dat_q;

  always_comb begin
    pipe_d = (READ_LAT)'({pipe_q, rd_issue});
    vld_d  = vld_q;
    dat_d  = dat_q;
    if (cap) begin
      vld_d = 1'b1;
      dat_d = rd_data;
    end else if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
      vld_q  <= 1'b0;
      dat_q  <= 16'h0000;
    end else begin
      pipe_q <= pipe_d;
      vld_q  <= vld_d;
      dat_q  <= dat_d;
    end
  end
endmodule

// File: rtl/conv_aip_host_sequencer.sv
// AIP host job sequencer: load MemIn0, configure, start, await/clear interrupt, read MemOut0.
// Optional CONV_HOST_TIMEOUT_EN adds an interrupt-wait watchdog with sticky err_timeout.
module conv_aip_host_sequencer
  import conv_aip_pkg::*;
#(
  parameter int READ_LAT       = 1,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_IN         = 32,
  parameter int MAX_OUT        = 64
) (
  input  logic        clk,
  input  logic        rst_a,
  input  logic        job_start,
  input  logic [5:0]  job_in_len,
  input  logic [6:0]  job_out_len,
  input  logic [4:0]  job_size,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic        aip_en_s,
  output logic [4:0]  aip_conf_dbus,
  output logic [31:0] aip_data_in,
  output logic        aip_write,
  output logic        aip_read,
  output logic        aip_start,
  input  logic [31:0] aip_data_out,
  input  logic        aip_int_req
);
  logic [3:0] state_q, state_d;
  logic [6:0] in_len_q, in_len_d, out_len_q, out_len_d, cnt_q, cnt_d;
  logic [4:0] size_q, size_d;
  logic       tmo_hit, rd_cap;
  logic       unused_hi;

  assign unused_hi = ^aip_data_out[31:16];
  assign aip_en_s  = 1'b1;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done      = (state_q == ST_FIN);

  conv_aip_rd_port #(.READ_LAT(READ_LAT)) u_rd_port (
    .clk       (clk),
    .rst       (rst_a),
    .rd_issue  (aip_read),
    .rd_data   (aip_data_out[15:0]),
    .out_ready (out_ready),
    .cap       (rd_cap),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always_comb begin
    state_d       = state_q;
    in_len_d      = in_len_q;
    out_len_d     = out_len_q;
    size_d        = size_q;
    cnt_d         = cnt_q;
    in_ready      = 1'b0;
    aip_write     = 1'b0;
    aip_read      = 1'b0;
    aip_start     = 1'b0;
    aip_conf_dbus = CFG_STATUS;
    aip_data_in   = 32'h0;
    case (state_q)
      ST_IDLE: if (job_start) begin
        in_len_d  = clamp_len({1'b0, job_in_len}, 7'(MAX_IN));
        out_len_d = clamp_len(job_out_len, 7'(MAX_OUT));
        size_d    = job_size;
        state_d   = ST_PTR_IN;
      end
      ST_PTR_IN: begin
        aip_write     = 1'b1;
        aip_conf_dbus = CFG_MEMIN0_PTR;
        cnt_d         = 7'd0;
        state_d       = ST_WR_IN;
      end
      ST_WR_IN: begin
        in_ready      = 1'b1;
        aip_conf_dbus = CFG_MEMIN0;
        if (in_valid) begin
          aip_write   = 1'b1;
          aip_data_in = {24'h0, in_data};
          cnt_d       = cnt_q + 7'd1;
          if (cnt_q + 7'd1 == in_len_q) state_d = ST_WR_CONF;
        end
      end
      ST_WR_CONF: begin
        aip_write     = 1'b1;
        aip_conf_dbus = CFG_CONFREG;
        aip_data_in   = {27'h0, size_q};
        state_d       = ST_START;
      end
      ST_START: begin
        aip_start = 1'b1;
        state_d   = ST_WAIT_INT;
      end
      ST_WAIT_INT: begin
        if (aip_int_req)  state_d = ST_CLR_INT;
        else if (tmo_hit) state_d = ST_FIN;
      end
      ST_CLR_INT: begin
        aip_write   = 1'b1;
        aip_data_in = INT_CLR_DONE;
        state_d     = ST_PTR_OUT;
      end
      ST_PTR_OUT: begin
        aip_write     = 1'b1;
        aip_conf_dbus = CFG_MEMOUT0_PTR;
        cnt_d         = 7'd0;
        state_d       = ST_RD_ISSUE;
      end
      ST_RD_ISSUE: begin
        aip_read      = 1'b1;
        aip_conf_dbus = CFG_MEMOUT0;
        state_d       = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        aip_conf_dbus = CFG_MEMOUT0;
        if (rd_cap) state_d = ST_RD_HOLD;
      end
      ST_RD_HOLD: if (out_valid && out_ready) begin
        cnt_d   = cnt_q + 7'd1;
        state_d = (cnt_q + 7'd1 == out_len_q) ? ST_FIN : ST_RD_ISSUE;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q   <= ST_IDLE;
      in_len_q  <= 7'd0;
      out_len_q <= 7'd0;
      size_q    <= 5'd0;
      cnt_q     <= 7'd0;
    end else begin
      state_q   <= state_d;
      in_len_q  <= in_len_d;
      out_len_q <= out_len_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef CONV_HOST_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;

  // Counter value equals cycles already spent in WAIT_INT; it idles at zero elsewhere.
  always_comb begin
    tmo_d   = (state_q == ST_WAIT_INT) ? tmo_q + 16'd1 : 16'd0;
    tmo_hit = (state_q == ST_WAIT_INT) && !aip_int_req && (tmo_q == 16'(TIMEOUT_CYCLES - 1));
    err_d   = err_q;
    if (state_q == ST_IDLE && job_start) err_d = 1'b0;
    else if (tmo_hit)                    err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      tmo_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_conv_aip_host_sequencer.sv
// Directed bench: small AIP responder model plus per-scenario tasks with hand-computed expectations.
module tb_conv_aip_host_sequencer;
  import conv_aip_pkg::*;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        job_start = 1'b0;
  logic [5:0]  job_in_len = 6'd0;
  logic [6:0]  job_out_len = 7'd0;
  logic [4:0]  job_size = 5'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b0;
  logic [31:0] aip_data_out = 32'h0;
  logic        aip_int_req = 1'b0;
  logic        in_ready, out_valid, busy, done, err_timeout;
  logic        aip_en_s, aip_write, aip_read, aip_start;
  logic [15:0] out_data;
  logic [4:0]  aip_conf_dbus;
  logic [31:0] aip_data_in;

  conv_aip_host_sequencer #(.READ_LAT(1), .TIMEOUT_CYCLES(100), .MAX_IN(32), .MAX_OUT(64)) dut (
    .clk(clk), .rst_a(rst_a), .job_start(job_start), .job_in_len(job_in_len),
    .job_out_len(job_out_len), .job_size(job_size), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .err_timeout(err_timeout), .aip_en_s(aip_en_s),
    .aip_conf_dbus(aip_conf_dbus), .aip_data_in(aip_data_in), .aip_write(aip_write),
    .aip_read(aip_read), .aip_start(aip_start), .aip_data_out(aip_data_out),
    .aip_int_req(aip_int_req)
  );

  int n_pass = 0, n_total = 0;

  // Stimulus controls, written only by the test tasks.
  int         clr_gen = 0, src_n = 0, int_mode = 0;
  logic       tog_mode = 1'b0, bp_mode = 1'b0, hold_ready = 1'b0;
  logic [7:0] src [64];

  // Monitor/model state, written only by the monitor.
  int          cyc = 0, seen_gen = 0, src_idx = 0, rd_ptr = 0, rd_n = 0, st_n = 0, done_n = 0;
  int          st_cyc = 0, done_cyc = 0, clr_cyc = 0, st_at_wr = 0, int_cd = 0;
  int          strobe_err = 0, rd_cfg_err = 0, hold_err = 0, stall_cnt = 0, stall_tot = 0;
  logic        int_nxt = 1'b0, hold_vld = 1'b0;
  logic [15:0] hold_dat = 16'h0;
  logic [31:0] dout_nxt = 32'hDEADBEEF;
  logic [4:0]  wr_cfg [$];
  logic [31:0] wr_dat [$];
  logic [15:0] out_log [$];

  initial forever #5 clk = ~clk;

  // Drives the AIP responder outputs and the sample/result stream handshakes.
  initial forever begin
    @(posedge clk); #1;
    aip_data_out = dout_nxt;
    aip_int_req  = int_nxt;
    if (src_idx < src_n && (!tog_mode || cyc[0] == 1'b0)) begin
      in_valid = 1'b1;
      in_data  = src[src_idx];
    end else begin
      in_valid = 1'b0;
      in_data  = 8'h00;
    end
    out_ready = !hold_ready && (!bp_mode || stall_cnt >= 5);
  end

  // Observes the DUT mid-cycle and models the AIP: MemOut0 word k reads as k*3.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (clr_gen != seen_gen) begin
      seen_gen = clr_gen;
      wr_cfg.delete(); wr_dat.delete(); out_log.delete();
      src_idx = 0; rd_ptr = 0; rd_n = 0; st_n = 0; done_n = 0; st_at_wr = 0;
      strobe_err = 0; rd_cfg_err = 0; hold_err = 0; stall_cnt = 0; stall_tot = 0; hold_vld = 1'b0;
    end
    if (rst_a) begin
      int_nxt = 1'b0; int_cd = 0; stall_cnt = 0; hold_vld = 1'b0; dout_nxt = 32'hDEADBEEF;
    end else begin
      if (int'(aip_write) + int'(aip_read) + int'(aip_start) > 1) strobe_err++;
      dout_nxt = 32'hDEADBEEF;
      if (aip_write) begin
        wr_cfg.push_back(aip_conf_dbus);
        wr_dat.push_back(aip_data_in);
        if (aip_conf_dbus == CFG_MEMOUT0_PTR) rd_ptr = 0;
        if (aip_conf_dbus == CFG_STATUS && aip_data_in == INT_CLR_DONE) begin
          int_nxt = 1'b0;
          clr_cyc = cyc;
        end
      end
      if (aip_read) begin
        rd_n++;
        if (aip_conf_dbus != CFG_MEMOUT0) rd_cfg_err++;
        dout_nxt = {16'hA5A5, 16'(rd_ptr * 3)};
        rd_ptr++;
      end
      if (aip_start) begin
        st_n++;
        st_cyc   = cyc;
        st_at_wr = wr_cfg.size();
        if (int_mode == 1) int_nxt = 1'b1;
        else if (int_mode == 0) int_cd = 20;
      end else if (int_cd > 0) begin
        int_cd--;
        if (int_cd == 0) int_nxt = 1'b1;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (in_valid && in_ready) src_idx++;
      if (out_valid) begin
        if (hold_vld && out_data !== hold_dat) hold_err++;
        if (out_ready) begin
          out_log.push_back(out_data);
          stall_cnt = 0;
          hold_vld  = 1'b0;
        end else begin
          stall_cnt++;
          stall_tot++;
          hold_vld = 1'b1;
          hold_dat = out_data;
        end
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  task automatic run_job(input logic [5:0] il, input logic [6:0] ol, input logic [4:0] sz,
                         input int ns, input int base, input int step);
    int k;
    for (int i = 0; i < ns; i++) src[i] = 8'(base + i * step);
    src_n = ns;
    clr_gen++;
    @(posedge clk); #1;
    job_start = 1'b1; job_in_len = il; job_out_len = ol; job_size = sz;
    @(posedge clk); #1;
    job_start = 1'b0;
    k = 0;
    while (k < 3000 && done_n == 0) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (done_n == 0) $display("FAIL job_done_wait: done not seen within %0d cycles", k);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({aip_write, aip_read, aip_start} !== 3'b000)
      $display("FAIL rst_strobes: got %b want 000", {aip_write, aip_read, aip_start});
    else n_pass++;
    n_total++;
    if (aip_conf_dbus !== CFG_STATUS) $display("FAIL rst_conf: got %h want %h", aip_conf_dbus, CFG_STATUS);
    else n_pass++;
    n_total++;
    if (aip_en_s !== 1'b1) $display("FAIL rst_en: got %b want 1", aip_en_s);
    else n_pass++;
    n_total++;
    if ({busy, done, err_timeout, in_ready, out_valid} !== 5'b0)
      $display("FAIL rst_flags: got %b want 00000", {busy, done, err_timeout, in_ready, out_valid});
    else n_pass++;
    n_total++;
    if (out_data !== 16'h0 || aip_data_in !== 32'h0)
      $display("FAIL rst_data: got out %h in %h want 0 0", out_data, aip_data_in);
    else n_pass++;
    @(posedge clk); #1;
    rst_a = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy, done, in_ready} !== 3'b000 || aip_conf_dbus !== CFG_STATUS)
      $display("FAIL idle_after_rst: got flags %b conf %h", {busy, done, in_ready}, aip_conf_dbus);
    else n_pass++;
  endtask

  task automatic test_basic;
    logic [4:0]  ecfg [8] = '{CFG_MEMIN0_PTR, CFG_MEMIN0, CFG_MEMIN0, CFG_MEMIN0, CFG_MEMIN0,
                               CFG_CONFREG, CFG_STATUS, CFG_MEMOUT0_PTR};
    logic [31:0] edat [8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd4, 32'd1, 32'd0};
    int bad = -1;
    run_job(6'd4, 7'd7, 5'd4, 4, 1, 1);
    for (int i = 0; i < 8 && i < wr_cfg.size(); i++)
      if (bad < 0 && (wr_cfg[i] !== ecfg[i] || wr_dat[i] !== edat[i])) bad = i;
    n_total++;
    if (wr_cfg.size() != 8 || bad >= 0)
      $display("FAIL basic_writes: got %0d writes, first bad index %0d; want 8 in order", wr_cfg.size(), bad);
    else n_pass++;
    n_total++;
    if (st_n != 1 || st_at_wr != 6)
      $display("FAIL basic_start: got %0d starts after %0d writes, want 1 after 6", st_n, st_at_wr);
    else n_pass++;
    n_total++;
    if (rd_n != 7 || rd_cfg_err != 0)
      $display("FAIL basic_reads: got %0d reads (%0d bad target), want 7", rd_n, rd_cfg_err);
    else n_pass++;
    bad = -1;
    for (int i = 0; i < out_log.size(); i++) if (bad < 0 && out_log[i] !== 16'(i * 3)) bad = i;
    n_total++;
    if (out_log.size() != 7 || bad >= 0)
      $display("FAIL basic_results: got %0d results, first bad index %0d; want 0,3..18", out_log.size(), bad);
    else n_pass++;
    n_total++;
    if (done_n != 1 || strobe_err != 0)
      $display("FAIL basic_done: got %0d done pulses, %0d strobe overlaps; want 1, 0", done_n, strobe_err);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || err_timeout !== 1'b0)
      $display("FAIL basic_idle: got busy %b err %b want 0 0", busy, err_timeout);
    else n_pass++;
  endtask

  task automatic test_back_pressure;
    logic [31:0] memin [$];
    logic [31:0] conf = 32'hFFFF_FFFF;
    int bad = -1;
    tog_mode = 1'b1;
    bp_mode  = 1'b1;
    run_job(6'd5, 7'd3, 5'd9, 5, 10, 10);
    tog_mode = 1'b0;
    bp_mode  = 1'b0;
    for (int i = 0; i < wr_cfg.size(); i++) begin
      if (wr_cfg[i] == CFG_MEMIN0) memin.push_back(wr_dat[i]);
      if (wr_cfg[i] == CFG_CONFREG) conf = wr_dat[i];
    end
    for (int i = 0; i < memin.size(); i++) if (bad < 0 && memin[i] !== 32'((i + 1) * 10)) bad = i;
    n_total++;
    if (memin.size() != 5 || bad >= 0 || src_idx != 5)
      $display("FAIL bp_samples: got %0d writes (%0d accepted), first bad %0d; want 10..50", memin.size(), src_idx, bad);
    else n_pass++;
    n_total++;
    if (conf !== 32'd9) $display("FAIL bp_confreg: got %0d want 9", conf);
    else n_pass++;
    n_total++;
    if (out_log.size() != 3 || out_log[0] !== 16'd0 || out_log[1] !== 16'd3 || out_log[2] !== 16'd6)
      $display("FAIL bp_results: got %0d results, want 0,3,6", out_log.size());
    else n_pass++;
    n_total++;
    if (hold_err != 0 || stall_tot != 15)
      $display("FAIL bp_hold: got %0d changes while stalled over %0d stall cycles, want 0 over 15", hold_err, stall_tot);
    else n_pass++;
  endtask

  task automatic test_boundary;
    int nin;
    run_job(6'd0, 7'd0, 5'd1, 3, 7, 1);
    nin = 0;
    foreach (wr_cfg[i]) if (wr_cfg[i] == CFG_MEMIN0) nin++;
    n_total++;
    if (nin != 1 || src_idx != 1) $display("FAIL len0_in: got %0d writes (%0d accepted) want 1", nin, src_idx);
    else n_pass++;
    n_total++;
    if (rd_n != 1 || out_log.size() != 1) $display("FAIL len0_out: got %0d reads want 1", rd_n);
    else n_pass++;
    run_job(6'd40, 7'd64, 5'd1, 40, 0, 1);
    nin = 0;
    foreach (wr_cfg[i]) if (wr_cfg[i] == CFG_MEMIN0) nin++;
    n_total++;
    if (nin != 32 || src_idx != 32) $display("FAIL len40_in: got %0d writes (%0d accepted) want 32", nin, src_idx);
    else n_pass++;
    n_total++;
    if (rd_n != 64 || out_log.size() != 64 || out_log[63] !== 16'd189)
      $display("FAIL len64_out: got %0d reads %0d results want 64, last 189", rd_n, out_log.size());
    else n_pass++;
    run_job(6'd20, 7'd100, 5'd1, 20, 0, 1);
    n_total++;
    if (rd_n != 64) $display("FAIL len100_out: got %0d reads want 64", rd_n);
    else n_pass++;
  endtask

  task automatic test_early_int;
    int_mode = 1;
    run_job(6'd2, 7'd2, 5'd3, 2, 5, 1);
    int_mode = 0;
    n_total++;
    if (clr_cyc - st_cyc != 2) $display("FAIL early_int: got clear %0d cycles after start want 2", clr_cyc - st_cyc);
    else n_pass++;
    n_total++;
    if (out_log.size() != 2 || out_log[1] !== 16'd3 || err_timeout !== 1'b0)
      $display("FAIL early_int_read: got %0d results err %b want 2 results err 0", out_log.size(), err_timeout);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int k = 0;
    hold_ready = 1'b1;
    for (int i = 0; i < 3; i++) src[i] = 8'(i + 40);
    src_n = 3;
    clr_gen++;
    @(posedge clk); #1;
    job_start = 1'b1; job_in_len = 6'd3; job_out_len = 7'd5; job_size = 5'd2;
    @(posedge clk); #1;
    job_start = 1'b0;
    while (k < 500 && out_valid !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL mid_reach_hold: out_valid %b after %0d cycles want 1", out_valid, k);
    else n_pass++;
    @(posedge clk); #2;
    rst_a = 1'b1;
    #1;
    n_total++;
    if ({aip_write, aip_read, aip_start, busy, done, out_valid, in_ready} !== 7'b0 ||
        aip_conf_dbus !== CFG_STATUS || aip_en_s !== 1'b1)
      $display("FAIL mid_rst_outputs: got %b conf %h en %b", {aip_write, aip_read, aip_start, busy, done, out_valid, in_ready},
               aip_conf_dbus, aip_en_s);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_data !== 16'h0 || aip_data_in !== 32'h0) $display("FAIL mid_rst_data: got %h %h want 0 0", out_data, aip_data_in);
    else n_pass++;
    @(posedge clk); #1;
    rst_a      = 1'b0;
    hold_ready = 1'b0;
    run_job(6'd4, 7'd7, 5'd4, 4, 1, 1);
    n_total++;
    if (wr_cfg.size() != 8 || wr_dat[1] !== 32'd1 || rd_n != 7 || out_log.size() != 7 || out_log[6] !== 16'd18 || done_n != 1)
      $display("FAIL mid_rerun: got %0d writes %0d reads %0d results %0d done", wr_cfg.size(), rd_n, out_log.size(), done_n);
    else n_pass++;
  endtask

`ifdef CONV_HOST_TIMEOUT_EN
  task automatic test_timeout;
    int_mode = 2;
    run_job(6'd2, 7'd3, 5'd1, 2, 1, 1);
    int_mode = 0;
    n_total++;
    if (err_timeout !== 1'b1) $display("FAIL tmo_err: got %b want 1", err_timeout);
    else n_pass++;
    n_total++;
    if (done_cyc - st_cyc != 101) $display("FAIL tmo_timing: got done %0d cycles after start want 101", done_cyc - st_cyc);
    else n_pass++;
    n_total++;
    if (rd_n != 0 || wr_cfg.size() != 4 || done_n != 1)
      $display("FAIL tmo_skip: got %0d reads %0d writes %0d done want 0 4 1", rd_n, wr_cfg.size(), done_n);
    else n_pass++;
    run_job(6'd1, 7'd1, 5'd1, 1, 1, 1);
    n_total++;
    if (err_timeout !== 1'b0 || out_log.size() != 1) $display("FAIL tmo_clear: got err %b results %0d want 0 1", err_timeout, out_log.size());
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_boundary();
    test_early_int();
    test_reset_mid();
`ifdef CONV_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
